audio_sample_sequencer: RTL and testbench
=========================================

// Module: audio_sample_sequencer
// PURPOSE
//  Sequences the audio CODEC sample path.
//  - Waits for a stereo sample and pops it with a one-cycle read.
//  - Passes left then right through ONE shared FIR engine using a start/done handshake per channel.
//  - Pushes the filtered pair to the CODEC with a one-cycle write.
//  - Sits between audio_codec and the FIR engine, replacing the direct read/write flag wiring and the duplicated per-channel filters.
// PARAMETERS
//  DATA_W     24    sample width, signed two's complement
//  TIMEOUT    1023  max cycles to wait for filt_done per channel; must be >= 1
//  STALL_W    8     width of the saturating stall counter
// PORTS
//  CLOCK_50         in   1       system clock, all logic on posedge
//  resetn           in   1       asynchronous active-low reset
//  bypass           in   1       1: skip the filter, loop samples straight through; sampled in IDLE only
//  read_ready       in   1       CODEC has a stereo sample available
//  readdata_left    in   DATA_W  CODEC left sample, valid while read_ready=1
//  readdata_right   in   DATA_W  CODEC right sample, valid while read_ready=1
//  read             out  1       one-cycle pop strobe to CODEC
//  write_ready      in   1       CODEC can accept a stereo sample
//  write            out  1       one-cycle push strobe to CODEC
//  writedata_left   out  DATA_W  left output sample, registered
//  writedata_right  out  DATA_W  right output sample, registered
//  filt_start       out  1       one-cycle request to the FIR engine
//  filt_sel         out  1       channel select: 0=left, 1=right; held from start until done/timeout
//  filt_din         out  DATA_W  FIR input sample; held from start until done/timeout
//  filt_done        in   1       FIR result valid; single-cycle pulse
//  filt_dout        in   DATA_W  FIR result, valid when filt_done=1
//  busy             out  1       1 in every state except IDLE
//  timeout_err      out  1       sticky; set on any filter timeout; cleared only by reset
//  stall_count      out  STALL_W saturating count of write-side stalls
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE.
//   - read, write, filt_start, filt_sel, busy, timeout_err = 0
//   - writedata_*, filt_din, stall_count, internal sample regs = 0
//  FSM states: IDLE, POP, FL_GO, FL_WAIT, FR_GO, FR_WAIT, WAIT_WR, PUSH.
//  IDLE:
//   - read_ready=1 -> latch readdata_left/right into sample regs and bypass into byp_q; go to POP.
//  POP:
//   - read=1 for exactly this cycle.
//   - Next state is WAIT_WR if byp_q=1, otherwise FL_GO.
//   - In bypass, writedata_* <= sample regs on the POP edge.
//  FL_GO:
//   - filt_start=1 for one cycle, filt_sel=0, filt_din=left sample.
//   - Clear the wait counter; go to FL_WAIT.
//  FL_WAIT:
//   - filt_done=1 -> left result reg <= filt_dout; go to FR_GO.
//   - Otherwise the counter increments.
//   - Counter reaches TIMEOUT with no done -> left result <= raw left sample, timeout_err <= 1, go to FR_GO.
//  FR_GO / FR_WAIT: same as FL_GO / FL_WAIT with filt_sel=1, right sample and right result.
//   - On leaving FR_WAIT: writedata_left/right <= left/right results (same edge).
//  WAIT_WR:
//   - write_ready=1 -> go to PUSH.
//   - Entry cycle (the first cycle in WAIT_WR) with write_ready=0 -> stall_count += 1, saturating at all-ones.
//  PUSH:
//   - write=1 for exactly this cycle; go to IDLE.
//   - writedata_* stay stable until the next sample overwrites them.
//  Strobes:
//   - read, write and filt_start are each high for exactly one cycle per sample.
//   - Never two of them in the same cycle.
//  Handshake edge cases:
//   - filt_done outside FL_WAIT/FR_WAIT is ignored.
//   - filt_done in the same cycle the counter hits TIMEOUT: done wins, timeout_err is not set.
//   - read_ready and write_ready outside IDLE/WAIT_WR are ignored; no sample is dropped or duplicated.
//  Latency:
//   - Bypass: read_ready to write = 3 cycles when write_ready=1 (IDLE->POP->WAIT_WR->PUSH).
//   - Filter path: 5 + dL + dR cycles, where dX = cycles from filt_start to filt_done.
//  Arithmetic: no arithmetic on samples; values pass bit-exact. Counter widths are clog2(TIMEOUT+1) and STALL_W.
//  Reset mid-operation: immediately returns to IDLE with all strobes low. The in-flight sample is discarded and not written.
// TESTING
//  T1 bypass=1, read_ready=1 with L=24'h123456, R=24'hFEDCBA, write_ready=1
//     -> read at cycle 1, write at cycle 3; writedata = 123456 / FEDCBA; filt_start never asserted.
//  T2 bypass=0, L=24'h000100, R=24'hFFFF00; model FIR returns done 4 cycles after start, value = din+1
//     -> filt_sel 0 then 1; write carries 000101 / FFFF01.
//  T3 FIR model never asserts done, TIMEOUT=8
//     -> each channel waits 8 cycles; output = raw samples; timeout_err=1 and stays 1 across 3 more samples.
//  T4 write_ready held 0 for 20 cycles on 300 consecutive samples
//     -> write only after write_ready rises; stall_count saturates at 8'hFF.
//  T5 resetn pulsed low while in FR_WAIT
//     -> all outputs reset asynchronously; no write issued; next sample processes normally.
//  T6 filt_done coincident with timeout cycle; spurious filt_done pulse in IDLE
//     -> filt_dout used, timeout_err=0; the IDLE pulse causes no state change.

Source files
------------

// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer: pops a stereo sample from the CODEC, filters left then right
// through one shared FIR engine (or bypasses it) and pushes the pair back to the CODEC.
module audio_sample_sequencer #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 1023,
  parameter int STALL_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              bypass,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              filt_start,
  output logic              filt_sel,
  output logic [DATA_W-1:0] filt_din,
  input  logic              filt_done,
  input  logic [DATA_W-1:0] filt_dout,
  output logic              busy,
  output logic              timeout_err,
  output logic [STALL_W-1:0] stall_count
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, POP, FL_GO, FL_WAIT, FR_GO, FR_WAIT, WAIT_WR, PUSH} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] smp_l_q, smp_l_d, smp_r_q, smp_r_d, res_l_q, res_l_d;
  logic [DATA_W-1:0] wd_l_q, wd_l_d, wd_r_q, wd_r_d, din_q, din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic byp_q, byp_d, sel_q, sel_d, terr_q, terr_d, first_q, first_d;
  logic read_q, read_d, write_q, write_d, start_q, start_d, busy_q, busy_d;
  logic last_wait;
  assign last_wait = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    smp_l_d = smp_l_q;
    smp_r_d = smp_r_q;
    res_l_d = res_l_q;
    wd_l_d  = wd_l_q;
    wd_r_d  = wd_r_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    byp_d   = byp_q;
    sel_d   = sel_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: if (read_ready) begin
        smp_l_d = readdata_left;
        smp_r_d = readdata_right;
        byp_d   = bypass;
        state_d = POP;
      end
      POP: begin
        state_d = byp_q ? WAIT_WR : FL_GO;
        wd_l_d  = byp_q ? smp_l_q : wd_l_q;
        wd_r_d  = byp_q ? smp_r_q : wd_r_q;
      end
      FL_GO: begin
        cnt_d   = '0;
        state_d = FL_WAIT;
      end
      // a done arriving on the last allowed cycle wins over the timeout
      FL_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (filt_done || last_wait) begin
          res_l_d = filt_done ? filt_dout : smp_l_q;
          terr_d  = terr_q | ~filt_done;
          state_d = FR_GO;
        end
      end
      FR_GO: begin
        cnt_d   = '0;
        state_d = FR_WAIT;
      end
      FR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (filt_done || last_wait) begin
          wd_l_d  = res_l_q;
          wd_r_d  = filt_done ? filt_dout : smp_r_q;
          terr_d  = terr_q | ~filt_done;
          state_d = WAIT_WR;
        end
      end
      WAIT_WR: begin
        stall_d = (first_q && !write_ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
        state_d = write_ready ? PUSH : WAIT_WR;
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    first_d = (state_d == WAIT_WR) && (state_q != WAIT_WR);
    read_d  = state_d == POP;
    write_d = state_d == PUSH;
    start_d = (state_d == FL_GO) || (state_d == FR_GO);
    busy_d  = state_d != IDLE;
    sel_d   = (state_d == FL_GO) ? 1'b0 : (state_d == FR_GO) ? 1'b1 : sel_d;
    din_d   = (state_d == FL_GO) ? smp_l_q : (state_d == FR_GO) ? smp_r_q : din_d;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      smp_l_q <= '0;
      smp_r_q <= '0;
      res_l_q <= '0;
      wd_l_q  <= '0;
      wd_r_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      byp_q   <= 1'b0;
      sel_q   <= 1'b0;
      terr_q  <= 1'b0;
      first_q <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_l_q <= smp_l_d;
      smp_r_q <= smp_r_d;
      res_l_q <= res_l_d;
      wd_l_q  <= wd_l_d;
      wd_r_q  <= wd_r_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      byp_q   <= byp_d;
      sel_q   <= sel_d;
      terr_q  <= terr_d;
      first_q <= first_d;
      read_q  <= read_d;
      write_q <= write_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end
  assign read            = read_q;
  assign write           = write_q;
  assign filt_start      = start_q;
  assign filt_sel        = sel_q;
  assign filt_din        = din_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  assign busy            = busy_q;
  assign timeout_err     = terr_q;
  assign stall_count     = stall_q;
endmodule

// File: tb/tb_audio_sample_sequencer.sv
// tb_audio_sample_sequencer: table vectors, hand sequences and random samples against a timeline model.
module tb_audio_sample_sequencer;
  localparam int TO = 8;
  logic CLOCK_50 = 1'b0, resetn = 1'b0, bypass = 1'b0, read_ready = 1'b0, write_ready = 1'b0, filt_done = 1'b0;
  logic [23:0] readdata_left = '0, readdata_right = '0, filt_dout = '0;
  logic read, write, filt_start, filt_sel, busy, timeout_err;
  logic [23:0] writedata_left, writedata_right, filt_din;
  logic [7:0] stall_count;
  int checks = 0, failures = 0;

  audio_sample_sequencer #(.DATA_W(24), .TIMEOUT(TO), .STALL_W(8)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .bypass(bypass), .read_ready(read_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right), .read(read),
    .write_ready(write_ready), .write(write), .writedata_left(writedata_left),
    .writedata_right(writedata_right), .filt_start(filt_start), .filt_sel(filt_sel),
    .filt_din(filt_din), .filt_done(filt_done), .filt_dout(filt_dout), .busy(busy),
    .timeout_err(timeout_err), .stall_count(stall_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_strobes"}, {read, write, filt_start, filt_sel, busy, timeout_err}, '0);
    check({tag, "_data"}, {writedata_left, writedata_right, filt_din}, '0);
    check({tag, "_stall"}, stall_count, '0);
  endtask

  // Expected outcome of one sample from the rules: write cycle, output pair, timeout, stall.
  function automatic void model(input logic b, input logic [23:0] l, r, add, input int dl, dr, rise,
                                output int wc, output logic [23:0] wl, wr, output logic to, st);
    int entry;
    if (b) begin
      wl = l; wr = r; to = 1'b0; entry = 2;
    end else begin
      wl = (dl > TO) ? l : l + add;
      wr = (dr > TO) ? r : r + add;
      to = (dl > TO) || (dr > TO);
      entry = 4 + ((dl > TO) ? TO : dl) + ((dr > TO) ? TO : dr);
    end
    st = rise > entry;
    wc = (st ? rise : entry) + 1;
  endfunction

  // Called at a negedge; cycle 0 is the IDLE cycle with read_ready high. FIR answers dX cycles after each start.
  task automatic run_sample(input logic b, input logic [23:0] l, r, add, input int dl, dr, rise, wc,
                            input logic [23:0] wl, wr, input logic terr, input logic [7:0] st, input int rst_at);
    int done_at = -1, sc = 0, rc = -1, wcy = -1, nrd = 0, nwr = 0, nst = 0, clash = 0, hold = 0;
    logic [23:0] res = '0, gl = '0, gr = '0;
    logic ibusy = 1'b1, pbusy = 1'b0;
    bypass = b; readdata_left = l; readdata_right = r;
    for (int c = 0; c < 80; c++) begin
      read_ready  = (c == 0);
      write_ready = (c >= rise);
      filt_done   = (c == done_at);
      filt_dout   = filt_done ? res : 24'($urandom);
      if (c > 0) begin
        readdata_left = 24'($urandom); readdata_right = 24'($urandom); bypass = 1'($urandom);
      end
      if (read) begin nrd++; rc = c; end
      if (c == 1) pbusy = busy;
      if (write) begin nwr++; wcy = c; gl = writedata_left; gr = writedata_right; end
      if (int'(read) + int'(write) + int'(filt_start) > 1) clash++;
      if (c == done_at && !filt_start && c - sc <= TO &&
          (filt_sel !== (nst == 2) || filt_din !== ((nst == 2) ? r : l))) hold++;
      if (filt_start) begin
        if (filt_sel !== (nst == 1) || filt_din !== ((nst == 1) ? r : l)) hold++;
        res = ((nst == 1) ? r : l) + add;
        done_at = c + ((nst == 1) ? dr : dl);
        sc = c;
        nst++;
      end
      if (c == rst_at) begin
        check("busy_before_reset", busy, 1'b1);
        #2 resetn = 1'b0;
        #1 chk_zero("async_reset");
        #1 resetn = 1'b1;
        filt_done = 1'b0; read_ready = 1'b0;
        return;
      end
      if (wcy >= 0 && c == wcy + 1) begin ibusy = busy; break; end
      @(negedge CLOCK_50);
    end
    read_ready = 1'b0; filt_done = 1'b0;
    check("read_cycle", rc, 1);
    check("read_count", nrd, 1);
    check("busy_in_pop", pbusy, 1'b1);
    check("start_count", nst, b ? 0 : 2);
    check("write_cycle", wcy, wc);
    check("write_count", nwr, 1);
    check("writedata_left", gl, wl);
    check("writedata_right", gr, wr);
    check("strobe_clash", clash, 0);
    check("filt_sel_din", hold, 0);
    check("busy_after_push", ibusy, 1'b0);
    check("timeout_err", timeout_err, terr);
    check("stall_count", stall_count, st);
  endtask

  typedef struct {
    logic b; logic [23:0] l, r, add; int dl, dr, rise, wc; logic [23:0] wl, wr; logic terr; logic [7:0] st;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic b, to, stl, mterr;
    logic [23:0] l, r, add, wl, wr;
    int dl, dr, rise, wc, mstall, nw;
    tbl[0] = '{1'b1, 24'h123456, 24'hFEDCBA, 24'h1, 1, 1, 0, 3, 24'h123456, 24'hFEDCBA, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 24'h000100, 24'hFFFF00, 24'h1, 4, 4, 0, 13, 24'h000101, 24'hFFFF01, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 24'h7FFFFF, 24'h800000, 24'h1, 8, 3, 0, 16, 24'h800000, 24'h800001, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 24'h111111, 24'h222222, 24'h1, 1000, 1000, 0, 21, 24'h111111, 24'h222222, 1'b1, 8'd0};
    tbl[4] = '{1'b1, 24'hABCDEF, 24'h000000, 24'h1, 1, 1, 10, 11, 24'hABCDEF, 24'h000000, 1'b1, 8'd1};
    tbl[5] = '{1'b0, 24'hFFFFFF, 24'h00000F, 24'h1, 2, 1, 0, 8, 24'h000000, 24'h000010, 1'b1, 8'd1};
    tbl[6] = '{1'b0, 24'h55AA55, 24'h0F0F0F, 24'h1, 1000, 5, 0, 18, 24'h55AA55, 24'h0F0F10, 1'b1, 8'd1};
    repeat (2) @(negedge CLOCK_50);
    chk_zero("reset");
    resetn = 1'b1;
    @(negedge CLOCK_50);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        // spurious done while idle must not move the FSM or touch the outputs
        filt_done = 1'b1; filt_dout = 24'h5A5A5A;
        @(negedge CLOCK_50);
        filt_done = 1'b0;
        repeat (3) begin
          check("idle_pulse_strobes", {busy, read, filt_start, write}, '0);
          check("idle_pulse_data", {writedata_left, writedata_right}, {24'h800000, 24'h800001});
          @(negedge CLOCK_50);
        end
      end
      run_sample(tbl[i].b, tbl[i].l, tbl[i].r, tbl[i].add, tbl[i].dl, tbl[i].dr, tbl[i].rise,
                 tbl[i].wc, tbl[i].wl, tbl[i].wr, tbl[i].terr, tbl[i].st, -1);
    end
    // reset while waiting on the right channel; the in-flight sample must never be written
    run_sample(1'b0, 24'h010203, 24'h040506, 24'h1, 2, 1000, 0, 0, '0, '0, 1'b0, 8'd0, 8);
    @(negedge CLOCK_50);
    nw = 0;
    repeat (30) begin
      nw += int'(write) + int'(read);
      @(negedge CLOCK_50);
    end
    check("no_write_after_reset", nw, 0);
    mterr = 1'b0; mstall = 0;
    model(1'b0, 24'h0A0B0C, 24'h0D0E0F, 24'h3, 3, 2, 0, wc, wl, wr, to, stl);
    run_sample(1'b0, 24'h0A0B0C, 24'h0D0E0F, 24'h3, 3, 2, 0, wc, wl, wr, 1'b0, 8'd0, -1);
    for (int s = 0; s < 300; s++) begin
      b = 1'($urandom); l = 24'($urandom); r = 24'($urandom); add = 24'($urandom);
      dl = int'($urandom_range(1, 7)); dr = int'($urandom_range(1, 7));
      model(b, l, r, add, dl, dr, 20, wc, wl, wr, to, stl);
      mterr |= to;
      if (stl && mstall < 255) mstall++;
      run_sample(b, l, r, add, dl, dr, 20, wc, wl, wr, mterr, 8'(mstall), -1);
    end
    check("stall_saturated", stall_count, 8'hFF);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    chk_zero("rereset");
    @(negedge CLOCK_50);
    mterr = 1'b0; mstall = 0;
    for (int s = 0; s < 150; s++) begin
      b = 1'($urandom); l = 24'($urandom); r = 24'($urandom); add = 24'($urandom);
      dl = int'($urandom_range(1, 12)); dr = int'($urandom_range(1, 12)); rise = int'($urandom_range(0, 30));
      model(b, l, r, add, dl, dr, rise, wc, wl, wr, to, stl);
      mterr |= to;
      if (stl && mstall < 255) mstall++;
      run_sample(b, l, r, add, dl, dr, rise, wc, wl, wr, mterr, 8'(mstall), -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
